// File: rtl/sha_message_scheduler.sv
// SHA-256 message schedule generator: latches one 16-word block and streams
// W[0..ROUNDS-1], WORDS_PER_CYCLE words per beat, with valid/ready on both sides.
module sha_message_scheduler #(
  parameter int WORDS_PER_CYCLE = 1,
  parameter int ROUNDS          = 64,
  parameter int IDX_W           = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [15:0][31:0]                 block_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [WORDS_PER_CYCLE-1:0][31:0]  w_o,
  output logic [IDX_W-1:0]                  round_o,
  output logic                              last_o
);

  localparam int WPC = WORDS_PER_CYCLE;
  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(ROUNDS - WPC);
  localparam logic [IDX_W-1:0] STEP       = IDX_W'(WPC);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                 state_q, state_d;
  logic [15:0][31:0]      hist_q, hist_d;
  logic [IDX_W-1:0]       round_q, round_d;
  logic [WPC-1:0][31:0]   new_w;
  logic                   fire;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // hist_q[j] holds W[round_q + j]; lane k of the next words may chain on lanes k-2, k-1
  for (genvar k = 0; k < WPC; k++) begin : g_lane
    logic [31:0] m2;
    logic [31:0] w_new;
    if (k >= 2) begin : g_chain
      assign m2 = g_lane[k-2].w_new;
    end else begin : g_hist
      assign m2 = hist_q[14+k];
    end
    assign w_new    = sig1(m2) + hist_q[9+k] + sig0(hist_q[1+k]) + hist_q[k];
    assign new_w[k] = w_new;
  end

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    round_d     = round_q;
    out_valid_o = (state_q == ST_RUN);
    last_o      = out_valid_o && (round_q == LAST_ROUND);
    fire        = out_valid_o && out_ready_i;
    in_ready_o  = (state_q == ST_IDLE) || (fire && last_o);

    if (flush_i) begin
      state_d = ST_IDLE;
      round_d = '0;
    end else if (in_valid_i && in_ready_o) begin
      state_d = ST_RUN;
      hist_d  = block_i;
      round_d = '0;
    end else if (fire) begin
      if (last_o) begin
        state_d = ST_IDLE;
        round_d = '0;
      end else begin
        round_d = round_q + STEP;
        hist_d  = {new_w, hist_q[15:WPC]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      round_q <= round_d;
    end
  end

  assign w_o     = out_valid_o ? hist_q[WPC-1:0] : '0;
  assign round_o = round_q;

endmodule

// File: tb/tb_sha_message_scheduler.sv
// Bench for sha_message_scheduler: WPC=1/4 instances stream the "abc" block,
// a WPC=2 instance covers stalls, back-to-back blocks, flush and async reset.
module tb_sha_message_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0][31:0] blk;

  logic fl1, iv1, ir1, ov1, or1, ls1;
  logic [0:0][31:0] w1;
  logic [5:0] rd1;
  logic fl2, iv2, ir2, ov2, or2, ls2;
  logic [1:0][31:0] w2;
  logic [5:0] rd2;
  logic fl4, iv4, ir4, ov4, or4, ls4;
  logic [3:0][31:0] w4;
  logic [5:0] rd4;

  sha_message_scheduler #(.WORDS_PER_CYCLE(1), .ROUNDS(64), .IDX_W(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(fl1), .in_valid_i(iv1), .in_ready_o(ir1),
    .block_i(blk), .out_valid_o(ov1), .out_ready_i(or1), .w_o(w1), .round_o(rd1), .last_o(ls1));
  sha_message_scheduler #(.WORDS_PER_CYCLE(2), .ROUNDS(64), .IDX_W(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush_i(fl2), .in_valid_i(iv2), .in_ready_o(ir2),
    .block_i(blk), .out_valid_o(ov2), .out_ready_i(or2), .w_o(w2), .round_o(rd2), .last_o(ls2));
  sha_message_scheduler #(.WORDS_PER_CYCLE(4), .ROUNDS(64), .IDX_W(6)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush_i(fl4), .in_valid_i(iv4), .in_ready_o(ir4),
    .block_i(blk), .out_valid_o(ov4), .out_ready_i(or4), .w_o(w4), .round_o(rd4), .last_o(ls4));

  int checks = 0;
  int errors = 0;
  int beats2 = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] q4[$];
  logic [31:0] w_exp[64];

  typedef struct {
    int          t;
    logic [31:0] w;
  } vec_t;
  vec_t kv[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule computed straight from the recurrence over the whole array
  task automatic build(input logic [15:0][31:0] b);
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w_exp[t] = b[t];
      else begin
        s0 = rotr(w_exp[t-15], 7) ^ rotr(w_exp[t-15], 18) ^ (w_exp[t-15] >> 3);
        s1 = rotr(w_exp[t-2], 17) ^ rotr(w_exp[t-2], 19) ^ (w_exp[t-2] >> 10);
        w_exp[t] = s1 + w_exp[t-7] + s0 + w_exp[t-16];
      end
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] q[$], input int base);
    for (int t = 0; t < 64; t++)
      chk(nm, (base + t < q.size()) ? q[base+t] : 32'hxxxxxxxx, w_exp[t]);
  endtask

  task automatic rand_blk(output logic [15:0][31:0] b);
    for (int i = 0; i < 16; i++) b[i] = $urandom;
  endtask

  task automatic accept2(input logic [15:0][31:0] b);
    blk = b;
    iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
  endtask

  task automatic run2(input bit rnd, input int nwords);
    int cyc;
    cyc = 0;
    while (q2.size() < nwords && cyc < 2000) begin
      or2 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    chk("run2_words", 32'(q2.size()), 32'(nwords));
    or2 = 1'b0;
  endtask

  // Beat monitors sample on the falling edge; a beat fires when valid && ready here
  always @(negedge clk) begin
    if (rst_n && ov1 && or1) begin
      chk("round1", 32'(rd1), 32'(q1.size() % 64));
      chk("last1", 32'(ls1), 32'((q1.size() % 64) == 63));
      q1.push_back(w1[0]);
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov4 && or4) begin
      chk("round4", 32'(rd4), 32'(q4.size() % 64));
      chk("last4", 32'(ls4), 32'((q4.size() % 64) == 60));
      for (int k = 0; k < 4; k++) q4.push_back(w4[k]);
    end
  end

  logic [1:0][31:0] pw2;
  logic [5:0] prd2;
  logic pls2;
  bit pstall = 1'b0;
  always @(negedge clk) begin
    if (rst_n && ov2) begin
      if (pstall) begin
        chk("hold_w0", w2[0], pw2[0]);
        chk("hold_w1", w2[1], pw2[1]);
        chk("hold_round", 32'(rd2), 32'(prd2));
        chk("hold_last", 32'(ls2), 32'(pls2));
      end
      pstall = !or2;
      pw2 = w2;
      prd2 = rd2;
      pls2 = ls2;
      if (or2) begin
        chk("round2", 32'(rd2), 32'(q2.size() % 64));
        chk("last2", 32'(ls2), 32'((q2.size() % 64) == 62));
        q2.push_back(w2[0]);
        q2.push_back(w2[1]);
        beats2++;
      end
    end else begin
      pstall = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0][31:0] abc, ba, bb;
    int b0, cyc;

    fl1 = 0; iv1 = 0; or1 = 0;
    fl2 = 0; iv2 = 0; or2 = 0;
    fl4 = 0; iv4 = 0; or4 = 0;
    blk = '0;
    abc = '0;
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;
    kv[0] = '{0, 32'h61626380};
    kv[1] = '{1, 32'h00000000};
    kv[2] = '{14, 32'h00000000};
    kv[3] = '{15, 32'h00000018};
    kv[4] = '{16, 32'h61626380};
    kv[5] = '{17, 32'h000F0000};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready2", 32'(ir2), 32'd1);
    chk("rst_valid2", 32'(ov2), 32'd0);
    chk("rst_round2", 32'(rd2), 32'd0);
    chk("rst_last2", 32'(ls2), 32'd0);
    chk("rst_w2", w2[0] | w2[1], 32'd0);
    chk("rst_ready1", 32'(ir1), 32'd1);
    chk("rst_valid4", 32'(ov4), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc" block on WPC=1 and WPC=4, no backpressure
    build(abc);
    blk = abc;
    iv1 = 1; iv4 = 1; or1 = 1; or4 = 1;
    @(posedge clk); #1;
    iv1 = 0; iv4 = 0;
    chk("first_w1", w1[0], 32'h61626380);
    chk("first_round1", 32'(rd1), 32'd0);
    chk("first_w4_l3", w4[3], 32'h00000000);
    for (int c = 0; c <= 64; c++) begin
      chk("valid1", 32'(ov1), 32'(c < 64));
      chk("valid4", 32'(ov4), 32'(c < 16));
      @(posedge clk); #1;
    end
    chk("idle_ready1", 32'(ir1), 32'd1);
    chk("idle_ready4", 32'(ir4), 32'd1);
    chk("q1_size", 32'(q1.size()), 32'd64);
    chk("q4_size", 32'(q4.size()), 32'd64);
    cmp("abc_wpc1", q1, 0);
    cmp("abc_wpc4", q4, 0);
    for (int i = 0; i < 6; i++) begin
      chk("known_wpc1", (kv[i].t < q1.size()) ? q1[kv[i].t] : 32'hxxxxxxxx, kv[i].w);
      chk("known_wpc4", (kv[i].t < q4.size()) ? q4[kv[i].t] : 32'hxxxxxxxx, kv[i].w);
    end
    or1 = 0; or4 = 0;

    // random backpressure, WPC=2
    for (int rep = 0; rep < 3; rep++) begin
      rand_blk(ba);
      build(ba);
      q2.delete();
      b0 = beats2;
      accept2(ba);
      run2(1'b1, 64);
      chk("beats2", 32'(beats2 - b0), 32'd32);
      cmp("stall_stream", q2, 0);
      chk("post_valid2", 32'(ov2), 32'd0);
      chk("post_ready2", 32'(ir2), 32'd1);
    end

    // back-to-back blocks with in_valid held high
    rand_blk(ba);
    rand_blk(bb);
    q2.delete();
    blk = ba;
    iv2 = 1; or2 = 1;
    @(posedge clk); #1;
    blk = bb;
    for (int c = 0; c < 32; c++) begin
      chk("b2b_valid_a", 32'(ov2), 32'd1);
      chk("b2b_ready_a", 32'(ir2), 32'(c == 31));
      @(posedge clk); #1;
    end
    iv2 = 0;
    chk("b2b_round_b", 32'(rd2), 32'd0);
    for (int c = 0; c < 32; c++) begin
      chk("b2b_valid_b", 32'(ov2), 32'd1);
      @(posedge clk); #1;
    end
    chk("b2b_end_valid", 32'(ov2), 32'd0);
    or2 = 0;
    chk("b2b_size", 32'(q2.size()), 32'd128);
    build(ba);
    cmp("b2b_a", q2, 0);
    build(bb);
    cmp("b2b_b", q2, 64);

    // flush at round 20 while stalled
    rand_blk(ba);
    q2.delete();
    accept2(ba);
    or2 = 1;
    cyc = 0;
    while (rd2 != 6'd20 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reach20", 32'(rd2), 32'd20);
    or2 = 0;
    @(posedge clk); #1;
    chk("stall20_round", 32'(rd2), 32'd20);
    chk("stall20_valid", 32'(ov2), 32'd1);
    fl2 = 1;
    @(posedge clk); #1;
    fl2 = 0;
    chk("flush_valid", 32'(ov2), 32'd0);
    chk("flush_ready", 32'(ir2), 32'd1);
    chk("flush_round", 32'(rd2), 32'd0);
    chk("flush_last", 32'(ls2), 32'd0);
    fl2 = 1;
    @(posedge clk); #1;
    fl2 = 0;
    chk("flush_idle_ready", 32'(ir2), 32'd1);
    rand_blk(bb);
    build(bb);
    q2.delete();
    accept2(bb);
    run2(1'b0, 64);
    cmp("after_flush", q2, 0);

    // async reset at round 40
    rand_blk(ba);
    q2.delete();
    accept2(ba);
    or2 = 1;
    cyc = 0;
    while (rd2 != 6'd40 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reach40", 32'(rd2), 32'd40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ov2), 32'd0);
    chk("arst_round", 32'(rd2), 32'd0);
    chk("arst_w", w2[0] | w2[1], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("arst_ready", 32'(ir2), 32'd1);
    b0 = q2.size();
    for (int c = 0; c < 4; c++) begin
      chk("arst_no_stale", 32'(ov2), 32'd0);
      @(posedge clk); #1;
    end
    chk("arst_no_push", 32'(q2.size()), 32'(b0));
    chk("arst_round_after", 32'(rd2), 32'd0);
    or2 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_message_scheduler.md
Name: sha_message_scheduler

Overview:
- Parametrised SHA-256 message schedule generator. It accepts one 16-word message block and streams the full schedule W[0..ROUNDS-1] to the compression core, WORDS_PER_CYCLE words per beat.
- Adds three things a fixed-depth expander lacks: valid/ready handshakes on both sides, output backpressure, and round indexing with a last flag.
- Sits between the block padder and the compression rounds.

Parameters:
- WORDS_PER_CYCLE, 1, schedule words emitted per output beat. Legal values: 1, 2, 4.
- ROUNDS, 64, total schedule words per block. Must be ≥16 and a multiple of WORDS_PER_CYCLE.
- IDX_W, 6, width of round index. Must satisfy 2^IDX_W ≥ ROUNDS.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous abort; discards the current block.
- in_valid_i  in  1  block available.
- in_ready_o  out  1  scheduler can accept a block.
- block_i  in  16x32  message block; word [0] = W[0] (first big-endian word).
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  consumer accepts beat.
- w_o  out  WORDS_PER_CYCLE x32  lane k = W[round_o+k].
- round_o  out  IDX_W  index of lane 0 word.
- last_o  out  1  beat contains W[ROUNDS-1].

Behaviour:
- Reset (rst_n low, async): state IDLE, in_ready_o=1, out_valid_o=0, w_o=0, round_o=0, last_o=0, history cleared.
- States: IDLE and RUN.
  - IDLE: in_ready_o=1, out_valid_o=0.
  - RUN: out_valid_o=1.
- Input accept: in_valid_i && in_ready_o.
  - Latch block_i into a 16-word history register.
  - Go to RUN with round_o=0.
  - First beat appears on the next cycle and carries W[0..WPC-1], taken directly from the block.
  - Latency from accept to first out_valid_o is 1 cycle.
- Output advance: out_valid_o && out_ready_i.
  - round_o += WPC.
  - History shifts by WPC words.
  - WPC new words are computed combinationally from the history and are in place for the next beat.
- Stall: out_valid_o && !out_ready_i. w_o, round_o and last_o hold stable; no state changes.
- Expansion, for t ≥ 16:
  - W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - For WPC>1, lane k may depend on lanes <k of the same beat. Words are chained within the cycle, not read from stale history.
- Words 0..15 are emitted from the latched block unchanged. Expansion starts at t=16.
- last_o = (round_o == ROUNDS-WPC) while out_valid_o.
- Last handshake:
  - State returns to IDLE.
  - in_ready_o is also high in that same cycle (in_ready_o = IDLE | (out_valid_o & out_ready_i & last_o)).
  - If in_valid_i is also high, the next block is accepted and RUN continues with round_o=0 next cycle. There is no bubble between blocks.
- in_ready_o is 0 in RUN except during the last-handshake cycle. in_valid_i is ignored otherwise.
- flush_i:
  - Next state IDLE, out_valid_o=0, round_o=0, last_o=0.
  - Takes priority over accept and advance in the same cycle.
  - In IDLE it is a no-op and in_ready_o stays 1.
- Async reset mid-block: output drops immediately, history is lost, and no partial beat is re-emitted after release.
- round_o width: IDX_W bits; it never exceeds ROUNDS-WPC while valid.

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), WPC=1, out_ready_i=1 → beats t=0..63 in consecutive cycles.
  - W16=0x61626380, W17=0x000F0000.
  - All 64 words match the software model.
  - last_o only at round_o=63; returns to IDLE after.
- Same block, WPC=4, ROUNDS=64 → 16 beats.
  - Beat 4 lanes = W16..W19 (W16=0x61626380, W17=0x000F0000).
  - Checks intra-cycle chaining; all 64 words match the WPC=1 run.
- Random out_ready_i (50%) with WPC=2 → outputs held stable during every stall; word stream identical to the no-stall run; exactly 32 beats.
- Two blocks back-to-back, in_valid_i held high → second block accepted on the last-handshake cycle of the first; round_o=0 on the very next beat; no idle cycle between blocks.
- flush_i at round_o=20 during a stall → next cycle out_valid_o=0, in_ready_o=1. A new block then streams from W0 with correct values.
- rst_n pulsed low at round_o=40 → out_valid_o=0 immediately; after release in_ready_o=1, round_o=0, and no stale beat appears.
